// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks pc from 0 to LAST_ADDR into an IF/ID register,
// honouring decode backpressure and branch/jump redirects.
module fetch_stage #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [DATA_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic                advance;

    // A redirect blocks the fetch of the (now stale) current pc.
    assign advance = (state_q == ST_RUN) && !redirect_valid
                     && (!ifid_valid_q || id_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN, ST_DONE: begin
                if (redirect_valid) begin
                    // Flush; an unpopulated target simply ends fetching.
                    ifid_valid_d = 1'b0;
                    if (redirect_pc <= LAST) begin
                        pc_d    = redirect_pc;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (state_q == ST_RUN) begin
                    if (advance) begin
                        ifid_instr_d = imem_instr;
                        ifid_pc_d    = pc_q;
                        ifid_valid_d = 1'b1;
                        if (pc_q == LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end else if (id_ready) begin
                    ifid_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign imem_rd_en = advance;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID contents are queued when
// stimulus is applied and compared when the DUT loads its IF/ID register.
module tb_fetch_stage;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [DATA_W-1:0] imem_instr;
    logic              id_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ifid_valid;
    logic [DATA_W-1:0] ifid_instr;
    logic [ADDR_W-1:0] ifid_pc;
    logic              done;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [DATA_W-1:0] mem [0:15];
    int total = 0;
    int bad   = 0;

    fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(14)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_instr(imem_instr),
        .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .done(done)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        reset = 1'b0;
    endtask

    // Reset with start/redirect asserted simultaneously; then idle without start.
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd3; id_ready = 1'b1;
        tick();
        start = 1'b0; redirect_valid = 1'b0; reset = 1'b0;
        total++;
        if ({ifid_valid, ifid_instr, ifid_pc, done, imem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b instr=%h pc=%0d done=%0b addr=%0d required all 0",
                     ifid_valid, ifid_instr, ifid_pc, done, imem_addr);
        end
        #1;
        total++;
        if (imem_rd_en !== 1'b0) begin
            bad++; $display("FAIL reset_rd_en: got %0b required 0", imem_rd_en);
        end
        redirect_valid = 1'b1; redirect_pc = 4'd5;
        tick(); tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_rd_en !== 1'b0 || imem_addr !== 4'd0 || ifid_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: rd_en=%0b addr=%0d valid=%0b required 0/0/0",
                     imem_rd_en, imem_addr, ifid_valid);
        end
    endtask

    // Full sequential run 0..14 with decode always ready.
    task automatic test_sequential();
        int fetches = 0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            e.instr = mem[i]; e.pc = 4'(i);
            sb.push_back(e);
        end
        for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) begin
            if (imem_rd_en === 1'b1) fetches++;
            tick();
            if (ifid_valid === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (ifid_instr !== e.instr || ifid_pc !== e.pc) begin
                    bad++;
                    $display("FAIL seq_fetch: instr=%h pc=%0d required instr=%h pc=%0d",
                             ifid_instr, ifid_pc, e.instr, e.pc);
                end
                $display("seq: pc=%0d instr=%h done=%0b", ifid_pc, ifid_instr, done);
                if (e.pc == 4'd14) begin
                    total++;
                    if (done !== 1'b1) begin
                        bad++; $display("FAIL seq_done: done=%0b required 1", done);
                    end
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL seq_timeout: %0d fetches outstanding required 0", sb.size());
            sb.delete();
        end
        if (imem_rd_en === 1'b1) fetches++;
        tick();
        total++;
        if (fetches != 15) begin
            bad++; $display("FAIL seq_fetch_count: got %0d required 15", fetches);
        end
        total++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 4'd14 || done !== 1'b1 || imem_addr !== 4'd14) begin
            bad++;
            $display("FAIL done_drain: valid=%0b ifid_pc=%0d done=%0b addr=%0d required 0/14/1/14",
                     ifid_valid, ifid_pc, done, imem_addr);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || imem_addr !== 4'd14) begin
            bad++; $display("FAIL done_start_ignored: done=%0b addr=%0d required 1/14", done, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (imem_rd_en !== 1'b0 || imem_addr !== 4'd2 || ifid_instr !== 32'h01CE5020
                || ifid_pc !== 4'd1 || ifid_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: rd_en=%0b addr=%0d instr=%h ifid_pc=%0d required 0/2/01ce5020/1",
                         imem_rd_en, imem_addr, ifid_instr, ifid_pc);
            end
            $display("stall: cycle=%0d addr=%0d ifid_pc=%0d", k, imem_addr, ifid_pc);
            tick();
        end
        id_ready = 1'b1;
        e.instr = mem[2]; e.pc = 4'd2; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (ifid_instr !== e.instr || ifid_pc !== e.pc || ifid_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: instr=%h pc=%0d required %h/%0d", ifid_instr, ifid_pc, e.instr, e.pc);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (imem_addr !== 4'd5) begin
            bad++; $display("FAIL redir_setup: addr=%0d required 5", imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 4'd2;
        #1;
        total++;
        if (imem_rd_en !== 1'b0) begin
            bad++; $display("FAIL redir_rd_en: got %0b required 0", imem_rd_en);
        end
        tick();
        redirect_valid = 1'b0;
        total++;
        if (ifid_valid !== 1'b0 || imem_addr !== 4'd2) begin
            bad++; $display("FAIL redir_flush: valid=%0b addr=%0d required 0/2", ifid_valid, imem_addr);
        end
        e.instr = mem[2]; e.pc = 4'd2; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (ifid_instr !== e.instr || ifid_pc !== e.pc || ifid_valid !== 1'b1) begin
            bad++;
            $display("FAIL redir_fetch: instr=%h pc=%0d required %h/%0d", ifid_instr, ifid_pc, e.instr, e.pc);
        end
        $display("redirect: ifid_pc=%0d instr=%h", ifid_pc, ifid_instr);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd0;
        tick();
        redirect_valid = 1'b0; id_ready = 1'b1;
        total++;
        if (ifid_valid !== 1'b0 || imem_addr !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL redir_over_stall: valid=%0b addr=%0d done=%0b required 0/0/0",
                     ifid_valid, imem_addr, done);
        end
        #1;
        total++;
        if (imem_rd_en !== 1'b1) begin
            bad++; $display("FAIL redir_stall_resume: rd_en=%0b required 1", imem_rd_en);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 4'd15;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || ifid_valid !== 1'b0 || imem_rd_en !== 1'b0 || imem_addr !== 4'd3) begin
            bad++;
            $display("FAIL oor_redirect: done=%0b valid=%0b rd_en=%0b addr=%0d required 1/0/0/3",
                     done, ifid_valid, imem_rd_en, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 4'd0;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || imem_addr !== 4'd0 || imem_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL done_redirect: done=%0b addr=%0d rd_en=%0b required 0/0/1", done, imem_addr, imem_rd_en);
        end
        e.instr = mem[0]; e.pc = 4'd0; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (ifid_instr !== e.instr || ifid_pc !== e.pc || ifid_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_resume: instr=%h pc=%0d required %h/%0d", ifid_instr, ifid_pc, e.instr, e.pc);
        end
        // Redirect to the last populated word is in range and fetches it once.
        redirect_valid = 1'b1; redirect_pc = 4'd14;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (done !== 1'b0 || imem_addr !== 4'd14 || ifid_valid !== 1'b0) begin
            bad++;
            $display("FAIL last_redirect: done=%0b addr=%0d valid=%0b required 0/14/0", done, imem_addr, ifid_valid);
        end
        e.instr = mem[14]; e.pc = 4'd14; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (ifid_pc !== e.pc || ifid_instr !== e.instr || done !== 1'b1 || imem_addr !== 4'd14) begin
            bad++;
            $display("FAIL last_fetch: pc=%0d done=%0b addr=%0d required 14/1/14", ifid_pc, done, imem_addr);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        total++;
        if (imem_addr !== 4'd7 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL midrun_setup: addr=%0d valid=%0b required 7/1", imem_addr, ifid_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({ifid_valid, ifid_instr, ifid_pc, done, imem_addr, imem_rd_en} !== '0) begin
            bad++;
            $display("FAIL midrun_reset: valid=%0b instr=%h pc=%0d done=%0b addr=%0d rd_en=%0b required all 0",
                     ifid_valid, ifid_instr, ifid_pc, done, imem_addr, imem_rd_en);
        end
        tick(); tick();
        total++;
        if (imem_rd_en !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 4'd0) begin
            bad++; $display("FAIL midrun_needs_start: rd_en=%0b valid=%0b required 0/0", imem_rd_en, ifid_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h018D4820;
        mem[1] = 32'h01CE5020;
        mem[2] = 32'h01494022;
        reset = 1'b1; start = 1'b0; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_stall();
        test_out_of_range();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
